// File: rtl/irrig_pkg.sv
// Shared types for the irrigation sequencer: state and error encodings, actuator bit positions.
package irrig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_DOSE  = 3'd2,
    ST_MIX   = 3'd3,
    ST_IRRIG = 3'd4,
    ST_DRAIN = 3'd5,
    ST_ALARM = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_CRIT     = 2'b01,
    ERR_FILL_TO  = 2'b10,
    ERR_DRAIN_TO = 2'b11
  } err_t;

  localparam int unsigned ACT_VE    = 0;
  localparam int unsigned ACT_VS    = 1;
  localparam int unsigned ACT_DOS   = 2;
  localparam int unsigned ACT_DRENO = 3;
  localparam int unsigned ACT_W     = 4;

  // One actuator per state at most, so exclusion holds by construction.
  function automatic logic [ACT_W-1:0] act_decode(input state_t s);
    logic [ACT_W-1:0] a;
    a = '0;
    case (s)
      ST_FILL:  a[ACT_VE]    = 1'b1;
      ST_IRRIG: a[ACT_VS]    = 1'b1;
      ST_DOSE:  a[ACT_DOS]   = 1'b1;
      ST_DRAIN: a[ACT_DRENO] = 1'b1;
      default:  a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Shared phase counter: clears on state entry, counts while enabled, flags the terminal count.
module phase_timer #(
  parameter int unsigned TW = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [TW-1:0] limit,
  output logic          done
);

  logic [TW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear)
      count <= '0;
    else if (enable)
      count <= count + 1'b1;
  end

  assign done = (count == limit);

endmodule

// File: rtl/irrigation_scheduler.sv
// Tank/irrigation phase sequencer (Moore). Define TIMEOUT_WATCHDOG_EN to enable FILL/DRAIN
// watchdog timeouts; without it those phases wait indefinitely for the level sensors.
module irrigation_scheduler
  import irrig_pkg::*;
#(
  parameter int unsigned DOSE_CYCLES  = 8,
  parameter int unsigned MIX_CYCLES   = 16,
  parameter int unsigned FILL_TIMEOUT = 64,
  parameter int unsigned CLEAN_EVERY  = 4,
  parameter int unsigned TW           = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_irrig,
  input  logic       adb,
  input  logic       low,
  input  logic       high,
  input  logic       critico,
  input  logic       ack,
  output logic       ve,
  output logic       vs,
  output logic       dos,
  output logic       dreno,
  output logic       alarm,
  output logic       busy,
  output logic [2:0] state_o,
  output logic [1:0] err
);

  localparam int unsigned CW = $clog2(CLEAN_EVERY + 1);
  localparam logic [CW-1:0] CLEAN_MAX = CW'(CLEAN_EVERY);
  localparam logic [TW-1:0] DOSE_LAST = TW'(DOSE_CYCLES - 1);
  localparam logic [TW-1:0] MIX_LAST  = TW'(MIX_CYCLES - 1);
  localparam logic [TW-1:0] FILL_LAST = TW'(FILL_TIMEOUT - 1);

  state_t          state, state_nx;
  err_t            err_q, err_nx;
  logic [CW-1:0]   clean_cnt, clean_nx;
  logic            adb_lat, adb_nx;
  logic [TW-1:0]   tlimit;
  logic            ten, tclr, tdone;
  logic            fault;
  logic [ACT_W-1:0] act;

  // Contradictory level sensors are treated exactly like the critical input.
  assign fault = critico | (high & low);

  phase_timer #(.TW(TW)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (tclr),
    .enable (ten),
    .limit  (tlimit),
    .done   (tdone)
  );

  always_comb begin
    tlimit = '1;
    ten    = 1'b0;
    case (state)
      ST_DOSE:  begin tlimit = DOSE_LAST; ten = 1'b1; end
      ST_MIX:   begin tlimit = MIX_LAST;  ten = 1'b1; end
      ST_FILL,
      ST_DRAIN: begin
        tlimit = FILL_LAST;
`ifdef TIMEOUT_WATCHDOG_EN
        ten    = 1'b1;
`else
        ten    = 1'b0;
`endif
      end
      default:  begin tlimit = '1; ten = 1'b0; end
    endcase
  end

  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    clean_nx = clean_cnt;
    adb_nx   = adb_lat;
    if (state != ST_ALARM && fault) begin
      state_nx = ST_ALARM;
      err_nx   = ERR_CRIT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clean_cnt == CLEAN_MAX) begin
            state_nx = ST_DRAIN;
          end else if (req_irrig) begin
            adb_nx = adb;
            if (!high)    state_nx = ST_FILL;
            else if (adb) state_nx = ST_DOSE;
            else          state_nx = ST_IRRIG;
          end
        end
        ST_FILL: begin
          if (high) begin
            state_nx = adb_lat ? ST_DOSE : ST_IRRIG;
          end
`ifdef TIMEOUT_WATCHDOG_EN
          else if (tdone) begin
            state_nx = ST_ALARM;
            err_nx   = ERR_FILL_TO;
          end
`endif
        end
        ST_DOSE:  if (tdone) state_nx = ST_MIX;
        ST_MIX:   if (tdone) state_nx = ST_IRRIG;
        ST_IRRIG: begin
          if (low || !req_irrig) begin
            state_nx = ST_IDLE;
            if (clean_cnt != CLEAN_MAX) clean_nx = clean_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (low) begin
            state_nx = ST_IDLE;
            clean_nx = '0;
          end
`ifdef TIMEOUT_WATCHDOG_EN
          else if (tdone) begin
            state_nx = ST_ALARM;
            err_nx   = ERR_DRAIN_TO;
          end
`endif
        end
        ST_ALARM: begin
          if (ack && !fault) begin
            state_nx = ST_IDLE;
            err_nx   = ERR_NONE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Any state change restarts the shared timer so every phase begins at zero.
  assign tclr = (state_nx != state);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      err_q     <= ERR_NONE;
      clean_cnt <= '0;
      adb_lat   <= 1'b0;
    end else begin
      state     <= state_nx;
      err_q     <= err_nx;
      clean_cnt <= clean_nx;
      adb_lat   <= adb_nx;
    end
  end

  assign act     = act_decode(state);
  assign ve      = act[ACT_VE];
  assign vs      = act[ACT_VS];
  assign dos     = act[ACT_DOS];
  assign dreno   = act[ACT_DRENO];
  assign alarm   = (state == ST_ALARM);
  assign busy    = (state != ST_IDLE);
  assign state_o = state;
  assign err     = err_q;

endmodule
